// File: rtl/decode_if.sv
// Fetch, writeback and execute-command lanes of the decode stage.
// The decode stage is the slave; the surrounding pipeline (or bench) is the master.
interface decode_if #(
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int PC_WIDTH        = 12
);
  logic [PMEM_WORD_WIDTH-1:0] in_instr;
  logic                       in_instr_valid;
  logic [PC_WIDTH-1:0]        in_pc;
  logic                       in_flush;
  logic                       in_wb_act_write_res_to_reg;
  logic [REG_IDX_WIDTH-1:0]   in_wb_res_reg_idx;
  logic [IALU_WORD_WIDTH-1:0] in_wb_res;

  logic                       out_act_ialu_add;
  logic                       out_act_incr_pc_is_res;
  logic                       out_act_jump_to_ialu_res;
  logic                       out_act_write_res_to_reg;
  logic [PC_WIDTH-1:0]        out_pc;
  logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
  logic [IALU_WORD_WIDTH-1:0] out_src1;
  logic [IALU_WORD_WIDTH-1:0] out_src2;
  logic                       out_wait_imm;

  modport slave (
    input  in_instr, in_instr_valid, in_pc, in_flush,
           in_wb_act_write_res_to_reg, in_wb_res_reg_idx, in_wb_res,
    output out_act_ialu_add, out_act_incr_pc_is_res, out_act_jump_to_ialu_res,
           out_act_write_res_to_reg, out_pc, out_res_reg_idx,
           out_src1, out_src2, out_wait_imm
  );

  modport master (
    output in_instr, in_instr_valid, in_pc, in_flush,
           in_wb_act_write_res_to_reg, in_wb_res_reg_idx, in_wb_res,
    input  out_act_ialu_add, out_act_incr_pc_is_res, out_act_jump_to_ialu_res,
           out_act_write_res_to_reg, out_pc, out_res_reg_idx,
           out_src1, out_src2, out_wait_imm
  );
endinterface

// File: rtl/decode.sv
// Instruction decode stage: one/two-word decoder, register file with writeback
// bypass, and a registered execute command.
//
// state    | meaning
// ST_FIRST | expecting an opcode word
// ST_IMM   | JMP/ADDI first word taken, expecting its immediate word
module decode #(
  parameter int OPCODE_WIDTH    = 4,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int PC_WIDTH        = 12
) (
  input logic    clock,
  input logic    reset,
  decode_if.slave bus
);
  localparam int NREG = 2 ** REG_IDX_WIDTH;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_IMM   = 1'b1;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LINK = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(4);

  logic [0:0]                 state, state_nxt;
  logic [REG_IDX_WIDTH-1:0]   rd_q, rd_nxt, rs1_q, rs1_nxt;
  logic                       jmp_q, jmp_nxt;
  logic [IALU_WORD_WIDTH-1:0] regs [NREG];

  logic                       add_nxt, incr_nxt, jump_nxt, write_nxt;
  logic [PC_WIDTH-1:0]        pc_nxt;
  logic [REG_IDX_WIDTH-1:0]   idx_nxt;
  logic [IALU_WORD_WIDTH-1:0] src1_nxt, src2_nxt;

  logic [OPCODE_WIDTH-1:0]    opcode;
  logic [REG_IDX_WIDTH-1:0]   f_rd, f_rs1, f_rs2;
  logic [IALU_WORD_WIDTH-1:0] op_rs1, op_rs2, op_rs1_q;

  assign opcode = bus.in_instr[PMEM_WORD_WIDTH-1 -: OPCODE_WIDTH];
  assign f_rd   = bus.in_instr[3*REG_IDX_WIDTH-1 -: REG_IDX_WIDTH];
  assign f_rs1  = bus.in_instr[2*REG_IDX_WIDTH-1 -: REG_IDX_WIDTH];
  assign f_rs2  = bus.in_instr[REG_IDX_WIDTH-1:0];

  // Same-cycle writeback wins over the stored register value.
  assign op_rs1   = (bus.in_wb_act_write_res_to_reg && bus.in_wb_res_reg_idx == f_rs1)
                    ? bus.in_wb_res : regs[f_rs1];
  assign op_rs2   = (bus.in_wb_act_write_res_to_reg && bus.in_wb_res_reg_idx == f_rs2)
                    ? bus.in_wb_res : regs[f_rs2];
  assign op_rs1_q = (bus.in_wb_act_write_res_to_reg && bus.in_wb_res_reg_idx == rs1_q)
                    ? bus.in_wb_res : regs[rs1_q];

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_q;
    rs1_nxt   = rs1_q;
    jmp_nxt   = jmp_q;
    add_nxt   = 1'b0;
    incr_nxt  = 1'b0;
    jump_nxt  = 1'b0;
    write_nxt = 1'b0;
    pc_nxt    = '0;
    idx_nxt   = '0;
    src1_nxt  = '0;
    src2_nxt  = '0;
    if (bus.in_flush) begin
      state_nxt = ST_FIRST;
      rd_nxt    = '0;
      rs1_nxt   = '0;
      jmp_nxt   = 1'b0;
    end else if (bus.in_instr_valid) begin
      if (state == ST_FIRST) begin
        if (opcode == OP_ADD) begin
          add_nxt   = 1'b1;
          write_nxt = 1'b1;
          pc_nxt    = bus.in_pc;
          idx_nxt   = f_rd;
          src1_nxt  = op_rs1;
          src2_nxt  = op_rs2;
        end else if (opcode == OP_LINK) begin
          incr_nxt  = 1'b1;
          write_nxt = 1'b1;
          pc_nxt    = bus.in_pc;
          idx_nxt   = f_rd;
        end else if (opcode == OP_JMP) begin
          state_nxt = ST_IMM;
          jmp_nxt   = 1'b1;
        end else if (opcode == OP_ADDI) begin
          state_nxt = ST_IMM;
          jmp_nxt   = 1'b0;
          rd_nxt    = f_rd;
          rs1_nxt   = f_rs1;
        end
      end else begin
        state_nxt = ST_FIRST;
        add_nxt   = 1'b1;
        pc_nxt    = bus.in_pc;
        if (jmp_q) begin
          jump_nxt = 1'b1;
          src1_nxt = IALU_WORD_WIDTH'(bus.in_instr);
        end else begin
          write_nxt = 1'b1;
          idx_nxt   = rd_q;
          src1_nxt  = op_rs1_q;
          src2_nxt  = IALU_WORD_WIDTH'(bus.in_instr);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                        <= ST_FIRST;
      rd_q                         <= '0;
      rs1_q                        <= '0;
      jmp_q                        <= 1'b0;
      bus.out_act_ialu_add         <= 1'b0;
      bus.out_act_incr_pc_is_res   <= 1'b0;
      bus.out_act_jump_to_ialu_res <= 1'b0;
      bus.out_act_write_res_to_reg <= 1'b0;
      bus.out_pc                   <= '0;
      bus.out_res_reg_idx          <= '0;
      bus.out_src1                 <= '0;
      bus.out_src2                 <= '0;
    end else begin
      state                        <= state_nxt;
      rd_q                         <= rd_nxt;
      rs1_q                        <= rs1_nxt;
      jmp_q                        <= jmp_nxt;
      bus.out_act_ialu_add         <= add_nxt;
      bus.out_act_incr_pc_is_res   <= incr_nxt;
      bus.out_act_jump_to_ialu_res <= jump_nxt;
      bus.out_act_write_res_to_reg <= write_nxt;
      bus.out_pc                   <= pc_nxt;
      bus.out_res_reg_idx          <= idx_nxt;
      bus.out_src1                 <= src1_nxt;
      bus.out_src2                 <= src2_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.in_wb_act_write_res_to_reg) begin
      regs[bus.in_wb_res_reg_idx] <= bus.in_wb_res;
    end
  end

  assign bus.out_wait_imm = (state == ST_IMM);
endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios followed by random traffic, all checked
// against a word-level reference model of the instruction set.
module tb_decode;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  decode_if #(.PMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4), .PC_WIDTH(12)) bus ();

  decode #(.OPCODE_WIDTH(4), .PMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16),
           .REG_IDX_WIDTH(4), .PC_WIDTH(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: register array plus a queue holding an unfinished first word.
  logic [15:0] m_reg [16];
  logic [15:0] m_pend [$];
  logic        e_add, e_incr, e_jmp, e_wr, e_wait, e_chk_pc, e_chk_idx;
  logic [11:0] e_pc;
  logic [3:0]  e_idx;
  logic [15:0] e_src1, e_src2;

  function automatic logic [15:0] m_read(input logic [3:0] i);
    if (bus.in_wb_act_write_res_to_reg && bus.in_wb_res_reg_idx == i) return bus.in_wb_res;
    return m_reg[i];
  endfunction

  task automatic m_bubble();
    {e_add, e_incr, e_jmp, e_wr} = '0;
    e_pc = '0; e_idx = '0; e_src1 = '0; e_src2 = '0;
    e_chk_pc = 1'b1; e_chk_idx = 1'b1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pend.delete();
    m_bubble();
    e_wait = 1'b0;
  endtask

  task automatic m_step();
    logic [15:0] w, first;
    w = bus.in_instr;
    m_bubble();
    if (bus.in_flush) begin
      m_pend.delete();
    end else if (bus.in_instr_valid) begin
      if (m_pend.size() == 0) begin
        case (w[15:12])
          4'h1: begin
            e_add = 1; e_wr = 1; e_idx = w[11:8];
            e_src1 = m_read(w[7:4]); e_src2 = m_read(w[3:0]); e_chk_pc = 0;
          end
          4'h2: begin
            e_incr = 1; e_wr = 1; e_idx = w[11:8]; e_pc = bus.in_pc;
          end
          4'h3, 4'h4: m_pend.push_back(w);
          default: ;
        endcase
      end else begin
        first = m_pend.pop_front();
        e_add = 1;
        if (first[15:12] == 4'h3) begin
          e_jmp = 1; e_src1 = w; e_pc = bus.in_pc; e_chk_idx = 0;
        end else begin
          e_wr = 1; e_idx = first[11:8]; e_src1 = m_read(first[7:4]); e_src2 = w; e_chk_pc = 0;
        end
      end
    end
    e_wait = (m_pend.size() != 0);
    if (bus.in_wb_act_write_res_to_reg) m_reg[bus.in_wb_res_reg_idx] = bus.in_wb_res;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".add"},  32'(bus.out_act_ialu_add), 32'(e_add));
    chk({tag, ".incr"}, 32'(bus.out_act_incr_pc_is_res), 32'(e_incr));
    chk({tag, ".jump"}, 32'(bus.out_act_jump_to_ialu_res), 32'(e_jmp));
    chk({tag, ".wr"},   32'(bus.out_act_write_res_to_reg), 32'(e_wr));
    chk({tag, ".src1"}, 32'(bus.out_src1), 32'(e_src1));
    chk({tag, ".src2"}, 32'(bus.out_src2), 32'(e_src2));
    chk({tag, ".wait"}, 32'(bus.out_wait_imm), 32'(e_wait));
    if (e_chk_pc)  chk({tag, ".pc"},  32'(bus.out_pc), 32'(e_pc));
    if (e_chk_idx) chk({tag, ".idx"}, 32'(bus.out_res_reg_idx), 32'(e_idx));
  endtask

  task automatic drive(input logic [15:0] instr, input logic valid, input logic [11:0] pc,
                       input logic flush, input logic we, input logic [3:0] widx,
                       input logic [15:0] wres);
    bus.in_instr = instr; bus.in_instr_valid = valid; bus.in_pc = pc; bus.in_flush = flush;
    bus.in_wb_act_write_res_to_reg = we; bus.in_wb_res_reg_idx = widx; bus.in_wb_res = wres;
  endtask

  task automatic cycle(input string tag);
    m_step();
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  initial begin
    drive('0, 0, '0, 0, 0, '0, '0);
    m_reset();
    #12;
    check_out("rst");
    @(posedge clock); #1;
    reset = 1'b1;

    drive(16'h0000, 0, 12'h000, 0, 1, 4'd3, 16'd5);       cycle("ld_r3");
    drive(16'h0000, 0, 12'h000, 0, 1, 4'd4, 16'd7);       cycle("ld_r4");
    drive(16'h1534, 1, 12'h010, 0, 0, 4'd0, 16'd0);       cycle("add");
    chk("add.src1_k", 32'(bus.out_src1), 32'd5);
    chk("add.src2_k", 32'(bus.out_src2), 32'd7);
    chk("add.idx_k",  32'(bus.out_res_reg_idx), 32'd5);

    drive(16'h1120, 1, 12'h012, 0, 1, 4'd2, 16'h00AA);    cycle("bypass");
    chk("bypass.src1_k", 32'(bus.out_src1), 32'h00AA);

    drive(16'h3000, 1, 12'h020, 0, 0, 4'd0, 16'd0);       cycle("jmp1");
    chk("jmp1.wait_k", 32'(bus.out_wait_imm), 32'd1);
    drive(16'h0100, 1, 12'h022, 0, 0, 4'd0, 16'd0);       cycle("jmp2");
    chk("jmp2.src1_k", 32'(bus.out_src1), 32'h0100);
    chk("jmp2.jump_k", 32'(bus.out_act_jump_to_ialu_res), 32'd1);

    drive(16'h0000, 0, 12'h000, 0, 1, 4'd1, 16'd3);       cycle("ld_r1");
    drive(16'h4710, 1, 12'h030, 0, 0, 4'd0, 16'd0);       cycle("addi1");
    drive(16'h0000, 0, 12'h000, 0, 0, 4'd0, 16'd0);       cycle("gap1");
    cycle("gap2");
    chk("gap2.wait_k", 32'(bus.out_wait_imm), 32'd1);
    drive(16'h0004, 1, 12'h032, 0, 0, 4'd0, 16'd0);       cycle("addi2");
    chk("addi2.src1_k", 32'(bus.out_src1), 32'd3);
    chk("addi2.src2_k", 32'(bus.out_src2), 32'd4);
    chk("addi2.idx_k",  32'(bus.out_res_reg_idx), 32'd7);

    drive(16'h3000, 1, 12'h040, 0, 0, 4'd0, 16'd0);       cycle("fl_jmp");
    drive(16'h1534, 1, 12'h042, 1, 0, 4'd0, 16'd0);       cycle("flush");
    chk("flush.wait_k", 32'(bus.out_wait_imm), 32'd0);
    drive(16'h1534, 1, 12'h044, 0, 0, 4'd0, 16'd0);       cycle("post_fl");
    chk("post_fl.add_k", 32'(bus.out_act_ialu_add), 32'd1);

    drive(16'h2900, 1, 12'h0FE, 0, 0, 4'd0, 16'd0);       cycle("link");
    chk("link.pc_k", 32'(bus.out_pc), 32'h0FE);

    drive(16'h1534, 1, 12'h100, 0, 0, 4'd0, 16'd0);       cycle("pre_rst");
    drive(16'h4710, 1, 12'h102, 0, 0, 4'd0, 16'd0);       cycle("rst_addi");
    drive(16'h0004, 1, 12'h104, 0, 0, 4'd0, 16'd0);
    reset = 1'b0;
    #1;
    m_reset();
    check_out("rst_mid");
    @(posedge clock); #1;
    reset = 1'b1;
    drive(16'h0000, 0, 12'h000, 0, 0, 4'd0, 16'd0);       cycle("after_rst");

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] instr;
      instr = {4'($urandom_range(0, 7)), 12'($urandom)};
      drive(instr, ($urandom_range(0, 99) < 85), 12'($urandom), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 30), 4'($urandom), 16'($urandom));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
